nnet_out_framer: RTL

//  Downstream stage of the HLS neural-net core inside noc_block_keras*.
//  The core's res_V stream carries 18-bit results with no tlast.

---
 rtl/nnet_out_framer_pkg.sv | 29 ++
 rtl/nnet_framer_fifo.sv | 78 +++++++
 rtl/nnet_out_framer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/nnet_out_framer_pkg.sv
// Shared definitions for the Keras output framer: bus widths, register
// addresses agreed between the vector wrapper and the noc block, and the
// FIFO entry layout.
package nnet_out_framer_pkg;

    localparam int NNET_HLS_W = 18;
    localparam int NNET_AXI_W = 32;

    localparam logic [7:0] SR_USER_SPP    = 8'd131;
    localparam logic [7:0] RB_SIZE_INPUT  = 8'd129;
    localparam logic [7:0] RB_SIZE_OUTPUT = 8'd130;

    // One FIFO entry: end-of-vector flag on top of the widened sample.
    typedef struct packed {
        logic                  last;
        logic [NNET_AXI_W-1:0] data;
    } nnet_beat_t;

    // Frame length actually used: a programmed length of zero means one
    // sample per vector, so every beat closes a frame.
    function automatic logic [31:0] nnet_eff_len(input logic [31:0] len);
        if (len == 32'd0) begin
            return 32'd1;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/nnet_framer_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented
// combinationally from the storage array; an empty FIFO presents zeros.
// A write is refused while full, even if a read happens in the same cycle.
module nnet_framer_fifo #(
    parameter int WIDTH = 33,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_r [0:(2**AW)-1];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign full_s  = (level_r == DEPTH_C);
    assign empty_s = (level_r == {(AW+1){1'b0}});
    assign wr_ok_s = wr_en & ~full_s;
    assign rd_ok_s = rd_en & ~empty_s;

    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

    // Pointer and occupancy tracking; pointers wrap naturally at the depth.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage write; no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Head-of-queue presentation, forced to zero when nothing is stored.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        if (!empty_s) begin
            rd_data = mem_r[rd_ptr_r];
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/nnet_out_framer.sv
// Output framer for the HLS neural-net core: widens each result to 32 bits,
// regenerates tlast every nnet_size_out samples and buffers the stream so
// the vector wrapper can apply backpressure. The vector length is latched
// on the first beat of each vector (cnt==0); cnt>0 means mid-vector.
module nnet_out_framer
    import nnet_out_framer_pkg::*;
#(
    parameter int HLS_W    = 18,
    parameter int SIGN_EXT = 1,
    parameter int FIFO_AW  = 5,
    parameter int LEN_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [LEN_W-1:0]      nnet_size_out,
    input  logic [HLS_W-1:0]      i_tdata,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [NNET_AXI_W-1:0] o_tdata,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic [31:0]           frame_count,
    output logic [FIFO_AW:0]      fifo_level
);

    logic [LEN_W-1:0]      cnt_r;
    logic [LEN_W-1:0]      len_r;
    logic [31:0]           frame_count_r;
    logic [LEN_W-1:0]      eff_len_s;
    logic                  beat_last_s;
    logic                  sign_bit_s;
    logic [NNET_AXI_W-1:0] wide_s;
    logic                  accept_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  out_fire_s;
    nnet_beat_t            fifo_din_s;
    nnet_beat_t            fifo_dout_s;

    assign i_tready   = ~fifo_full_s & ~reset & ~clear;
    assign accept_s   = i_tvalid & i_tready;
    assign o_tvalid   = ~fifo_empty_s;
    assign out_fire_s = o_tvalid & o_tready;
    assign o_tdata    = fifo_dout_s.data;
    assign o_tlast    = fifo_dout_s.last;
    assign frame_count = frame_count_r;

    // Frame length for the current beat: the live input on a first beat,
    // the latched copy for the rest of the vector.
    always_comb begin
        eff_len_s = {LEN_W{1'b0}};
        if (cnt_r == {LEN_W{1'b0}}) begin
            eff_len_s = LEN_W'(nnet_eff_len(32'(nnet_size_out)));
        end else begin
            eff_len_s = LEN_W'(nnet_eff_len(32'(len_r)));
        end
    end

    assign beat_last_s = (cnt_r == (eff_len_s - LEN_W'(1)));

    // Widening of the HLS result into the 32-bit wrapper word.
    always_comb begin
        sign_bit_s = 1'b0;
        if (SIGN_EXT != 0) begin
            sign_bit_s = i_tdata[HLS_W-1];
        end else begin
            sign_bit_s = 1'b0;
        end
        wide_s = {{(NNET_AXI_W-HLS_W){sign_bit_s}}, i_tdata};
    end

    assign fifo_din_s = '{last: beat_last_s, data: wide_s};

    // Sample counter and length latch; a flush drops any partial vector.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r <= {LEN_W{1'b0}};
            len_r <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            if (cnt_r == {LEN_W{1'b0}}) begin
                len_r <= nnet_size_out;
            end
            if (beat_last_s) begin
                cnt_r <= {LEN_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + LEN_W'(1);
            end
        end
    end

    // Completed-vector counter; only a full reset zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_r <= 32'd0;
        end else if (clear) begin
            frame_count_r <= frame_count_r;
        end else if (out_fire_s && o_tlast) begin
            frame_count_r <= frame_count_r + 32'd1;
        end
    end

    nnet_framer_fifo #(
        .WIDTH (NNET_AXI_W + 1),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_data (fifo_din_s),
        .wr_en   (accept_s),
        .full    (fifo_full_s),
        .rd_en   (o_tready),
        .rd_data (fifo_dout_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

endmodule
